// File: rtl/m_spi_master_n_if.sv
// ---------------------------------------------------------------------------
// m_spi_master_n_if
// Groups the control handshake and SPI pin signals of m_spi_master_n.
//   master modport : seen from the SPI master (takes requests, drives pins)
//   slave  modport : seen from the requester/board side
// Signals: start, mode{CPOL,CPHA}, div, ss_sel, tx_data -> master
//          rx_data, busy, done                          <- master
//          SCLK_MASTER, SS_N_MASTER, MOSI_MASTER        <- master
//          MISO_MASTER                                  -> master
// Optional macro SPI_LSB_FIRST_EN adds the lsb_first request bit.
// ---------------------------------------------------------------------------
interface m_spi_master_n_if #(
  parameter int DATA_W = 64,
  parameter int DIV_W  = 8,
  parameter int NUM_SS = 1,
  parameter int SS_W   = 1
);
  logic              start;
  logic [1:0]        mode;
  logic [DIV_W-1:0]  div;
  logic [SS_W-1:0]   ss_sel;
  logic [DATA_W-1:0] tx_data;
`ifdef SPI_LSB_FIRST_EN
  logic              lsb_first;
`endif
  logic [DATA_W-1:0] rx_data;
  logic              busy;
  logic              done;
  logic              SCLK_MASTER;
  logic [NUM_SS-1:0] SS_N_MASTER;
  logic              MOSI_MASTER;
  logic              MISO_MASTER;

  modport master (
`ifdef SPI_LSB_FIRST_EN
    input  lsb_first,
`endif
    input  start, mode, div, ss_sel, tx_data, MISO_MASTER,
    output rx_data, busy, done, SCLK_MASTER, SS_N_MASTER, MOSI_MASTER
  );

  modport slave (
`ifdef SPI_LSB_FIRST_EN
    output lsb_first,
`endif
    output start, mode, div, ss_sel, tx_data, MISO_MASTER,
    input  rx_data, busy, done, SCLK_MASTER, SS_N_MASTER, MOSI_MASTER
  );
endinterface

// File: rtl/m_spi_master_n.sv
// ---------------------------------------------------------------------------
// m_spi_master_n
// Parametrised full-duplex SPI master with run-time mode 0-3, programmable
// SCLK divider (half-period = div+1 clk), NUM_SS slave selects and done/busy
// handshake. All request inputs are latched on an accepted start.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : m_spi_master_n_if.master (request, result and SPI pin signals)
// Optional macro SPI_LSB_FIRST_EN: adds bus.lsb_first; when set, tx bit 0 is
// sent first and received bits enter at the MSB. Undefined: MSB first always.
// ---------------------------------------------------------------------------
module m_spi_master_n #(
  parameter int DATA_W = 64,
  parameter int DIV_W  = 8,
  parameter int NUM_SS = 1,
  parameter int SS_W   = 1
) (
  input  logic             clk,
  input  logic             reset,
  m_spi_master_n_if.master bus
);

  localparam int                EDGE_W    = $clog2(2 * DATA_W + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL, S_DONE} state_t;

  state_t            r_state, w_next_state;
  logic [DIV_W-1:0]  r_div, r_cnt;
  logic [EDGE_W-1:0] r_edge;      // SCLK edges already produced in XFER
  logic              r_cpha;
  logic [SS_W-1:0]   r_ss;
  logic [DATA_W-1:0] r_tx, r_rx, r_rx_data;
  logic              r_sclk, r_mosi;
  logic [NUM_SS-1:0] w_ss_n;
  logic              w_busy, w_done, w_accept, w_tick, w_edge, w_last_edge;
  logic              w_odd_edge, w_sample, w_shift, w_lsb_in, w_lsb;

  // Bit order helpers: which bit leaves first, and what remains afterwards.
  function automatic logic first_bit(input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? d[0] : d[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] drop_bit(input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? (d >> 1) : (d << 1);
  endfunction

`ifdef SPI_LSB_FIRST_EN
  logic r_lsb;
  assign w_lsb_in = bus.lsb_first;
  assign w_lsb    = r_lsb;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_lsb <= 1'b0;
    else if (w_accept) r_lsb <= w_lsb_in;
  end
`else
  assign w_lsb_in = 1'b0;
  assign w_lsb    = 1'b0;
`endif

  // A request is taken in IDLE, or in DONE for back-to-back transfers.
  assign w_accept    = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_tick      = (r_cnt == r_div);
  assign w_edge      = (r_state == S_XFER) && w_tick;
  assign w_last_edge = (r_edge == LAST_EDGE);
  // r_edge counts completed edges, so the edge about to happen is odd when r_edge is even.
  assign w_odd_edge  = ~r_edge[0];
  assign w_sample    = w_edge && (r_cpha ? ~w_odd_edge : w_odd_edge);
  // CPHA=0 already drove the first bit at LEAD entry, so it shifts on even edges but not the last.
  assign w_shift     = w_edge && (r_cpha ? w_odd_edge : (~w_odd_edge && !w_last_edge));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next_state = S_LEAD;
      S_LEAD:  begin
        w_busy = 1'b1;
        if (w_tick) w_next_state = S_XFER;
      end
      S_XFER:  begin
        w_busy = 1'b1;
        if (w_edge && w_last_edge) w_next_state = S_TRAIL;
      end
      S_TRAIL: begin
        w_busy = 1'b1;
        if (w_tick) w_next_state = S_DONE;
      end
      S_DONE:  begin
        w_done       = 1'b1;
        w_next_state = bus.start ? S_LEAD : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Selected line is low for the whole busy window; an out-of-range index selects none.
  always_comb begin
    w_ss_n = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (w_busy && (r_ss == SS_W'(i))) w_ss_n[i] = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  // NOTE: the shift and result registers are reset too, because a reset must clear rx_data at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div     <= '0;
      r_cnt     <= '0;
      r_edge    <= '0;
      r_cpha    <= 1'b0;
      r_ss      <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
    end else begin
      if (r_state == S_DONE) r_rx_data <= r_rx;

      if (w_accept) begin
        r_div  <= bus.div;
        r_cpha <= bus.mode[0];
        r_ss   <= bus.ss_sel;
        r_cnt  <= '0;
        r_edge <= '0;
        r_rx   <= '0;
        r_sclk <= bus.mode[1];          // SCLK idles at the new CPOL from LEAD on
        if (!bus.mode[0]) begin
          r_mosi <= first_bit(bus.tx_data, w_lsb_in);
          r_tx   <= drop_bit(bus.tx_data, w_lsb_in);
        end else begin
          r_mosi <= 1'b0;
          r_tx   <= bus.tx_data;
        end
      end else begin
        if (w_busy) r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
        if (w_edge) begin
          r_sclk <= ~r_sclk;
          r_edge <= r_edge + 1'b1;
        end
        if (w_sample) begin
          r_rx <= w_lsb ? {bus.MISO_MASTER, r_rx[DATA_W-1:1]}
                        : {r_rx[DATA_W-2:0], bus.MISO_MASTER};
        end
        if (w_shift) begin
          r_mosi <= first_bit(r_tx, w_lsb);
          r_tx   <= drop_bit(r_tx, w_lsb);
        end
        if (r_state == S_DONE) r_mosi <= 1'b0;   // back to 0 on return to IDLE
      end
    end
  end

  assign bus.rx_data     = r_rx_data;
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.SCLK_MASTER = r_sclk;
  assign bus.SS_N_MASTER = w_ss_n;
  assign bus.MOSI_MASTER = r_mosi;

endmodule

// File: tb/tb_m_spi_master_n.sv
// ---------------------------------------------------------------------------
// tb_m_spi_master_n
// Self-checking bench for m_spi_master_n (DATA_W=8, NUM_SS=4, SS_W=3).
// A behavioural SPI slave counts SCLK pin edges, launches its word on the
// launch edges of the selected mode and captures MOSI on the capture edges.
// Expected latency, select pattern and received words come from plain
// arithmetic on the transfer parameters.
// ---------------------------------------------------------------------------
module tb_m_spi_master_n;
  localparam int DW     = 8;
  localparam int DIV_W  = 8;
  localparam int NUM_SS = 4;
  localparam int SS_W   = 3;

  logic clk = 1'b0;
  logic reset;
  logic sl_miso = 1'b0;
  bit   sl_loop = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  m_spi_master_n_if #(.DATA_W(DW), .DIV_W(DIV_W), .NUM_SS(NUM_SS), .SS_W(SS_W)) bus ();

  m_spi_master_n #(.DATA_W(DW), .DIV_W(DIV_W), .NUM_SS(NUM_SS), .SS_W(SS_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.MISO_MASTER = sl_loop ? bus.MOSI_MASTER : sl_miso;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bit position of wire slot 'slot' in a word for the given order.
  function automatic int slot_bit(input int slot, input bit lsb);
    return lsb ? slot : DW - 1 - slot;
  endfunction

  // One complete transfer against the slave model (or MOSI->MISO loopback).
  task automatic run_xfer(input logic [1:0] md, input logic [7:0] dv, input logic [2:0] sel,
                          input logic [7:0] tx, input logic [7:0] sw, input bit lp,
                          input bit lsb, input string tag);
    int         lat, k, edges, slot;
    logic [3:0] ss_exp;
    logic [7:0] srx;
    logic       prev_sclk;
    bit         ss_bad;
    lat    = 1 + (int'(dv) + 1) * (2 * DW + 2);
    ss_exp = 4'b1111;
    if (sel < 3'd4) ss_exp[sel[1:0]] = 1'b0;
    srx    = 8'h00;
    ss_bad = 1'b0;
    edges  = 0;

    @(negedge clk);
    sl_loop        = lp;
    sl_miso        = md[0] ? 1'b0 : sw[slot_bit(0, lsb)];
    bus.start      = 1'b1;
    bus.mode       = md;
    bus.div        = dv;
    bus.ss_sel     = sel;
    bus.tx_data    = tx;
`ifdef SPI_LSB_FIRST_EN
    bus.lsb_first  = lsb;
`endif
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    k = 1;
    check({tag, " lead sclk"}, bus.SCLK_MASTER, md[1]);
    check({tag, " lead busy"}, bus.busy, 1'b1);
    if (!md[0]) check({tag, " first mosi"}, bus.MOSI_MASTER, tx[slot_bit(0, lsb)]);
    prev_sclk = bus.SCLK_MASTER;

    while (bus.done !== 1'b1 && k <= lat + 4) begin
      if (bus.SS_N_MASTER !== ss_exp) ss_bad = 1'b1;
      if (bus.SCLK_MASTER !== prev_sclk) begin
        edges++;
        if (md[0] ? (edges % 2 == 0) : (edges % 2 == 1)) begin
          slot = (edges - 1) / 2;
          if (slot < DW) srx[slot_bit(slot, lsb)] = bus.MOSI_MASTER;
        end else begin
          slot = md[0] ? (edges - 1) / 2 : edges / 2;
          if (slot < DW) sl_miso = sw[slot_bit(slot, lsb)];
        end
      end
      prev_sclk = bus.SCLK_MASTER;
      @(negedge clk);
      #1;
      k++;
    end

    check({tag, " done latency"}, k, lat);
    check({tag, " busy in done"}, bus.busy, 1'b0);
    check({tag, " ss_n during xfer"}, ss_bad, 1'b0);
    check({tag, " sclk edges"}, edges, 2 * DW);
    check({tag, " slave saw mosi"}, srx, tx);
    @(negedge clk);
    #1;
    check({tag, " rx_data"}, bus.rx_data, lp ? tx : sw);
    check({tag, " done one cycle"}, bus.done, 1'b0);
    check({tag, " idle sclk"}, bus.SCLK_MASTER, md[1]);
    check({tag, " idle ss_n"}, bus.SS_N_MASTER, 4'b1111);
    check({tag, " idle mosi"}, bus.MOSI_MASTER, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] md;
    logic [7:0] dv, tx, sw;
    logic [2:0] sel;
    int         k, edges;
    logic       prev;
    bit         seen_done;

    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.mode    = 2'd0;
    bus.div     = '0;
    bus.ss_sel  = '0;
    bus.tx_data = '0;
`ifdef SPI_LSB_FIRST_EN
    bus.lsb_first = 1'b0;
`endif
    #1;
    check("reset rx_data", bus.rx_data, 8'h00);
    check("reset busy", bus.busy, 1'b0);
    check("reset done", bus.done, 1'b0);
    check("reset sclk", bus.SCLK_MASTER, 1'b0);
    check("reset ss_n", bus.SS_N_MASTER, 4'b1111);
    check("reset mosi", bus.MOSI_MASTER, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Loopback, mode 0, div 1: done 37 cycles after start, 16 edges.
    run_xfer(2'd0, 8'd1, 3'd0, 8'hA5, 8'h00, 1'b1, 1'b0, "basic");

    // Every mode against a slave returning C3.
    for (int m = 0; m < 4; m++)
      run_xfer(2'(m), 8'd1, 3'd0, 8'h3C, 8'hC3, 1'b0, 1'b0, $sformatf("mode%0d", m));

    // Slave select decoding, including an out-of-range index.
    run_xfer(2'd1, 8'd0, 3'd2, 8'h5A, 8'h96, 1'b0, 1'b0, "ss_sel2");
    run_xfer(2'd2, 8'd0, 3'd5, 8'hE7, 8'h18, 1'b0, 1'b0, "ss_sel5");

    for (int i = 0; i < 6; i++) begin
      md  = 2'($urandom_range(0, 3));
      dv  = 8'($urandom_range(0, 3));
      sel = 3'($urandom_range(0, 7));
      tx  = 8'($urandom);
      sw  = 8'($urandom);
      run_xfer(md, dv, sel, tx, sw, 1'b0, 1'b0, $sformatf("rand%0d", i));
    end

    // Back-to-back: start held high through DONE; mid-transfer input changes ignored.
    sl_loop = 1'b1;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.mode    = 2'd0;
    bus.div     = 8'd0;
    bus.ss_sel  = 3'd0;
    bus.tx_data = 8'h01;
`ifdef SPI_LSB_FIRST_EN
    bus.lsb_first = 1'b0;
`endif
    @(negedge clk);
    #1;
    k = 1;
    check("b2b first busy", bus.busy, 1'b1);
    bus.tx_data = 8'hFF;
    bus.mode    = 2'd3;
    while (bus.done !== 1'b1 && k <= 25) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("b2b first latency", k, 19);
    bus.tx_data = 8'h80;
    bus.mode    = 2'd0;
    @(negedge clk);
    #1;
    check("b2b second lead busy", bus.busy, 1'b1);
    check("b2b second lead done", bus.done, 1'b0);
    check("b2b first rx_data", bus.rx_data, 8'h01);
    bus.start = 1'b0;
    k = 1;
    while (bus.done !== 1'b1 && k <= 25) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("b2b second latency", k, 19);
    @(negedge clk);
    #1;
    check("b2b second rx_data", bus.rx_data, 8'h80);
    check("b2b back to idle", bus.busy, 1'b0);

    // Reset at SCLK edge 7 of a mode-0 transfer aborts with no done pulse.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.mode    = 2'd0;
    bus.div     = 8'd1;
    bus.ss_sel  = 3'd1;
    bus.tx_data = 8'hA5;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    edges = 0;
    k     = 0;
    prev  = bus.SCLK_MASTER;
    while (edges < 7 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
      if (bus.SCLK_MASTER !== prev) edges++;
      prev = bus.SCLK_MASTER;
    end
    check("abort reached edge 7", edges, 7);
    check("abort ss_n before reset", bus.SS_N_MASTER, 4'b1101);
    reset = 1'b1;
    #1;
    check("abort sclk", bus.SCLK_MASTER, 1'b0);
    check("abort ss_n", bus.SS_N_MASTER, 4'b1111);
    check("abort busy", bus.busy, 1'b0);
    check("abort rx_data", bus.rx_data, 8'h00);
    check("abort mosi", bus.MOSI_MASTER, 1'b0);
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    reset = 1'b0;
    repeat (60) begin
      @(negedge clk);
      #1;
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    check("abort no done", seen_done, 1'b0);

`ifdef SPI_LSB_FIRST_EN
    run_xfer(2'd0, 8'd1, 3'd0, 8'h01, 8'h00, 1'b1, 1'b1, "lsb_first");
    run_xfer(2'd1, 8'd0, 3'd3, 8'h4D, 8'hB2, 1'b0, 1'b1, "lsb_first_slave");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
